// File: rtl/perf_counter_ctrl_if.sv
// CSR access bundle between the core's CSR unit (master) and perf_counter_ctrl (slave).
// valid/ready: csr_req is a one-cycle request that is always accepted; csr_ack answers it exactly one cycle later.
interface perf_counter_ctrl_if;
    logic        csr_req;
    logic        csr_we;
    logic [3:0]  csr_addr;
    logic [31:0] csr_wdata;
    logic        csr_ack;
    logic [31:0] csr_rdata;
    logic        csr_err;

    modport master (
        output csr_req, csr_we, csr_addr, csr_wdata,
        input  csr_ack, csr_rdata, csr_err
    );

    modport slave (
        input  csr_req, csr_we, csr_addr, csr_wdata,
        output csr_ack, csr_rdata, csr_err
    );
endinterface

// File: rtl/perf_counter_ctrl.sv
// Performance counter bank controller: CSR block, count-enable gating,
// measurement-window FSM and cycle-counter overflow interrupt.
module perf_counter_ctrl #(
    parameter int NUM_EVENTS = 32,
    parameter int CNT_W      = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    perf_counter_ctrl_if.slave          csr,
    input  logic                        instruction_retired_i,
    input  logic [NUM_EVENTS-1:0]       event_signals_i,
    output logic                        cycle_count_en_o,
    output logic                        instret_gated_o,
    output logic [NUM_EVENTS-1:0]       event_gated_o,
    input  logic [CNT_W-1:0]            cycle_count_i,
    input  logic [CNT_W-1:0]            instret_count_i,
    input  logic [NUM_EVENTS*CNT_W-1:0] event_counts_flat_i,
    output logic                        irq_o,
    output logic [1:0]                  state_dbg_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t          state_q, state_d;
    logic            cyc_en_q, ins_en_q, win_mode_q, frz_q, irq_en_q;
    logic [31:0]     evmask_q, window_q, remain_q, remain_d;
    logic [4:0]      evsel_q;
    logic            done_q, done_d, ovf_q, ovf_d, done_set, ovf_set;
    logic            ack_q, err_q, irq_q;
    logic [31:0]     rdata_q, rd_mux;
    logic            unmapped;
    logic            wr, wr_ctrl, wr_status, start, stop;
    logic            active, gate;

    assign wr        = csr.csr_req & csr.csr_we;
    assign wr_ctrl   = wr & (csr.csr_addr == 4'd0);
    assign wr_status = wr & (csr.csr_addr == 4'd3);
    assign start     = wr_ctrl & csr.csr_wdata[5];
    assign stop      = wr_ctrl & csr.csr_wdata[6];

    assign active           = ~win_mode_q | (state_q == RUN);
    assign gate             = active & ~(frz_q & ovf_q);
    assign cycle_count_en_o = cyc_en_q & gate;
    assign instret_gated_o  = instruction_retired_i & ins_en_q & gate;
    assign event_gated_o    = event_signals_i & evmask_q & {NUM_EVENTS{gate}};
    assign irq_o            = irq_q;
    assign state_dbg_o      = state_q;

    assign csr.csr_ack   = ack_q;
    assign csr.csr_rdata = rdata_q;
    assign csr.csr_err   = err_q;

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        done_set = 1'b0;
        if (state_q == RUN) begin
            if (remain_q == 32'd1) begin
                state_d  = DONE;
                remain_d = '0;
                done_set = 1'b1;
            end else begin
                remain_d = remain_q - 32'd1;
            end
        end
        // stop beats start in the same write; stop also leaves DONE for IDLE
        if (stop) begin
            state_d  = IDLE;
            remain_d = remain_q;
            done_set = 1'b0;
        end else if (start) begin
            remain_d = window_q;
            if (window_q != 32'd0) begin
                state_d = RUN;
            end else begin
                state_d  = DONE;
                done_set = 1'b1;
            end
        end
    end

    assign ovf_set = (cycle_count_i == {CNT_W{1'b1}}) & cycle_count_en_o;
    assign done_d  = done_set | (done_q & ~(wr_status & csr.csr_wdata[2]));
    assign ovf_d   = ovf_set  | (ovf_q  & ~(wr_status & csr.csr_wdata[3]));

    always_comb begin
        rd_mux   = '0;
        unmapped = 1'b0;
        case (csr.csr_addr)
            4'd0:    rd_mux = {27'd0, irq_en_q, frz_q, win_mode_q, ins_en_q, cyc_en_q};
            4'd1:    rd_mux = evmask_q;
            4'd2:    rd_mux = window_q;
            4'd3:    rd_mux = {28'd0, ovf_q, done_q, state_q};
            4'd4:    rd_mux = remain_q;
            4'd5:    rd_mux = cycle_count_i;
            4'd6:    rd_mux = instret_count_i;
            4'd7:    rd_mux = {27'd0, evsel_q};
            4'd8:    rd_mux = event_counts_flat_i[evsel_q*CNT_W +: CNT_W];
            default: unmapped = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            remain_q   <= '0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            cyc_en_q   <= 1'b0;
            ins_en_q   <= 1'b0;
            win_mode_q <= 1'b0;
            frz_q      <= 1'b0;
            irq_en_q   <= 1'b0;
            evmask_q   <= '0;
            window_q   <= '0;
            evsel_q    <= '0;
            ack_q      <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            irq_q    <= irq_en_q & (done_q | ovf_q);
            ack_q    <= csr.csr_req;
            err_q    <= csr.csr_req & unmapped;
            rdata_q  <= (csr.csr_req & ~csr.csr_we) ? rd_mux : '0;
            if (wr_ctrl) begin
                cyc_en_q   <= csr.csr_wdata[0];
                ins_en_q   <= csr.csr_wdata[1];
                win_mode_q <= csr.csr_wdata[2];
                frz_q      <= csr.csr_wdata[3];
                irq_en_q   <= csr.csr_wdata[4];
            end
            if (wr && csr.csr_addr == 4'd1) evmask_q <= csr.csr_wdata;
            if (wr && csr.csr_addr == 4'd2) window_q <= csr.csr_wdata;
            if (wr && csr.csr_addr == 4'd7) evsel_q  <= csr.csr_wdata[4:0];
        end
    end

endmodule

// File: doc/perf_counter_ctrl.md
# perf_counter_ctrl

CSR-mapped controller for the `performance_counters` bank. It gates the bank's count enables per a software-programmed configuration (cycle/instret enable, 32-bit event mask) and runs a measurement-window state machine that counts for exactly N cycles and then stops. It detects cycle-counter overflow and raises an interrupt, and serves single-cycle-latency CSR reads and writes, including reads of bank counts. It sits between the core's CSR unit and the counter bank.

## Interface
- NUM_EVENTS, 32, number of event lines (fixed 32 in this revision)
- CNT_W, 32, counter width read back from the bank
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- csr_req  in  1  access request, one cycle per access
- csr_we  in  1  1 = write, 0 = read
- csr_addr  in  4  register index
- csr_wdata  in  32  write data
- csr_ack  out  1  pulses exactly one cycle after each csr_req
- csr_rdata  out  32  read data, valid with csr_ack, else 0
- csr_err  out  1  with csr_ack: unmapped address
- instruction_retired  in  1  raw retire pulse from the pipeline
- event_signals  in  32  raw event lines
- cycle_count_en  out  1  to bank
- instret_gated  out  1  to bank `instruction_retired`
- event_gated  out  32  to bank `event_signals`
- cycle_count, instret_count  in  32 each  from bank
- event_counts_flat  in  32*32  bank event counts; event i at [32*i+31:32*i]
- irq  out  1  level interrupt

## Operation
- Registers:
  - 0 CTRL RW:
    - b0 cyc_en, b1 ins_en, b2 win_mode, b3 freeze_on_ovf, b4 irq_en
    - b5 start, W1, reads 0
    - b6 stop, W1, reads 0
  - 1 EVMASK RW
  - 2 WINDOW RW
  - 3 STATUS:
    - b[1:0] state, RO
    - b2 done, W1C
    - b3 ovf, W1C
  - 4 REMAIN RO
  - 5 CYCLE RO
  - 6 INSTRET RO
  - 7 EVSEL RW, b[4:0]
  - 8 EVCOUNT RO: event_counts[EVSEL]
  - 9–15 unmapped: csr_err=1, rdata=0, no side effect
- Writes to RO fields are ignored without error.
- active:
  - 1 when win_mode=0.
  - When win_mode=1, active = (state==RUN).
- frozen = freeze_on_ovf & ovf.
- Gating, combinational:
  - cycle_count_en = cyc_en & active & !frozen
  - instret_gated = instruction_retired & ins_en & active & !frozen
  - event_gated = event_signals & EVMASK & {32{active & !frozen}}
- FSM states: IDLE=0, RUN=1, DONE=2.
  - IDLE/DONE + start: if WINDOW≠0, go to RUN with REMAIN=WINDOW. If WINDOW=0, go directly to DONE and set done.
  - RUN: REMAIN decrements every cycle. On an edge where REMAIN==1, go to DONE with REMAIN=0 and set done.
  - RUN + stop: go to IDLE, REMAIN holds.
  - start and stop in the same write: stop wins.
  - start while in RUN: restarts, REMAIN reloads.
- The FSM advances regardless of win_mode. Only gating depends on win_mode.
- ovf sets on an edge where cycle_count==32'hFFFFFFFF and cycle_count_en=1.
- Sticky set and W1C clear in the same cycle: set wins.
- irq = irq_en & (done | ovf), registered.
- WINDOW written during RUN affects only the next start.

## Timing
- Reset values:
  - All registers 0, state IDLE, REMAIN 0.
  - csr_ack, csr_rdata, csr_err, irq all 0.
  - cycle_count_en=0. instret_gated=0 and event_gated=0 regardless of inputs.
- CSR:
  - Request sampled at edge E. Write takes effect at E. ack/rdata/err are registered and valid in cycle E+1.
  - Back-to-back requests are allowed. Each gets its own ack.
  - Reads return register/bank values sampled at E.
- Window: start sampled at edge E0 with WINDOW=W. RUN covers cycles E0..E0+W-1, exactly W counted cycles. DONE is visible from E0+W. irq is visible one cycle after done sets.
- Gating has zero latency relative to raw inputs and current state.
- Reset asserted mid-RUN: immediately IDLE, all gates 0 asynchronously.

## Test plan
- Reset, then read regs 0–8 → all 0. cycle_count_en=0 and event_gated=0 with event_signals=32'hFFFFFFFF.
- CTRL=0x03 (free run), EVMASK=0x3, event_signals=0x7 → event_gated=0x3. Instret gated through. Unmapped read of addr 12 → err=1, rdata=0.
- WINDOW=10, CTRL=win_mode|cyc_en|irq_en|start → cycle_count_en high exactly 10 cycles. STATUS reads state=2, done=1. irq=1. W1C done → irq drops next cycle.
- WINDOW=0 plus start → DONE next cycle, cycle_count_en never asserts. Start+stop in the same write → state IDLE.
- Bank cycle_count forced to 32'hFFFFFFFF with freeze_on_ovf=1 → ovf=1 next cycle, all gates 0, irq=1. W1C ovf → counting resumes.
- Start with WINDOW=100, assert reset at REMAIN=40 → all outputs 0 at once. After release, state=IDLE, REMAIN=0.
